input_capture_ctrl: RTL and testbench
=====================================

INPUT_CAPTURE_CTRL -- requirements
Module: input_capture_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_N, default 17: debounce counter width; a level must hold 2^DEBOUNCE_N-1 cycles to be accepted.
REQ-002 SHALL have parameter BASE_ADDR, default 24'h000100: first memory word address of the capture ring.
REQ-003 SHALL have parameter RING_WORDS, default 16: number of ring words, range 2..256.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: capture FIFO entries, power of two.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 sw  input  5  raw switch levels, asynchronous.
REQ-008 btn  input  1  raw capture button, asynchronous, bouncing.
REQ-009 out_addr  output  24  memory write address toward the memory controller input port.
REQ-010 out_data  output  16  memory write data, {seq[10:0], sw_sync[4:0]}.
REQ-011 out_valid  output  1  out_addr/out_data hold a pending write.
REQ-012 out_ready  input  1  memory controller accepts the write this cycle.
REQ-013 drop_cnt  output  8  count of captures lost to a full FIFO, saturating.
REQ-014 level  output  3  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-015 sw and btn SHALL each pass through a 2-flop synchronizer before use.
REQ-016 Debouncer FSM SHALL have states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-017 RELEASED->PRESS_WAIT on sync btn=1; PRESS_WAIT->RELEASED on btn=0, clearing the counter; PRESS_WAIT->PRESSED when the counter reaches all-ones.
REQ-018 PRESSED->RELEASE_WAIT on btn=0; RELEASE_WAIT->PRESSED on btn=1; RELEASE_WAIT->RELEASED when the counter reaches all-ones; the counter clears on every state entry.
REQ-019 The PRESS_WAIT->PRESSED transition SHALL raise a one-cycle capture pulse in the following cycle; no other transition pulses.
REQ-020 On a capture pulse with FIFO not full, SHALL push {seq, sw_sync}, then increment seq (11-bit, wraps 2047->0).
REQ-021 On a capture pulse with FIFO full and no pop that cycle, SHALL drop the capture, leave seq unchanged, and increment drop_cnt, saturating at 255.
REQ-022 A pop and a push in the same cycle while full SHALL both succeed; the level is unchanged.
REQ-023 out_valid SHALL equal (level!=0); out_data SHALL be the FIFO head; out_addr SHALL be BASE_ADDR+wr_idx.
REQ-024 With the FIFO empty, a push at cycle t SHALL give out_valid=1 at t+1.
REQ-025 A pop SHALL occur when out_valid&out_ready; wr_idx SHALL then increment, wrapping RING_WORDS-1->0.
REQ-026 out_addr/out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 reset SHALL set the FSM to RELEASED, clear the debounce counter and synchronizers, and clear level, seq, wr_idx and drop_cnt.
REQ-029 Outputs after reset: out_valid=0, level=0, drop_cnt=0, out_addr=BASE_ADDR, out_data=0.
REQ-030 reset mid-press or mid-handshake SHALL discard FIFO contents; no write SHALL be presented until a new full press.

Configuration
REQ-031 Macro ICC_DROP_OLDEST_EN, when defined: a capture into a full FIFO SHALL overwrite the oldest entry (head advances) and increment seq; drop_cnt still counts the loss.
REQ-032 Without ICC_DROP_OLDEST_EN: the new capture SHALL be discarded per REQ-021.

Structure
REQ-033 Package icc_pkg SHALL hold the debouncer state encoding, the 16-bit data and 24-bit address width constants, and the seq width constant (11).
REQ-034 The debouncer (synchronizer + FSM + counter) SHALL be sub-module key_debouncer, with a one-cycle pulse output.

Verification (DEBOUNCE_N=3, RING_WORDS=4, FIFO_DEPTH=4)
REQ-035 Verify clean press: btn=1 held 12 cycles, sw=5'h0A, out_ready=1 -> exactly one write, out_addr=24'h000100, out_data=16'h000A.
REQ-036 Verify bounce rejection: btn toggling every 3 cycles for 30 cycles, then low -> no capture pulse, out_valid stays 0.
REQ-037 Verify ring wrap: 5 presses with out_ready=1 -> addresses 0x100, 0x101, 0x102, 0x103, 0x100 and seq 0..4 in out_data[15:5].
REQ-038 Verify overflow (macro off): out_ready=0, 6 presses -> level=4, drop_cnt=2, queued seq 0..3; then out_ready=1 -> 4 writes in order.
REQ-039 Verify overflow (ICC_DROP_OLDEST_EN): same stimulus -> queued seq 2..5, drop_cnt=2.
REQ-040 Verify reset mid-operation: reset for 1 cycle with level=3 and out_ready=0 -> next cycle out_valid=0, level=0, out_addr=0x100, drop_cnt=0.

Source files
------------

// File: rtl/icc_pkg.sv
// Shared widths, debouncer state encoding and capture-word packing for input_capture_ctrl.
package icc_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;
  localparam int SEQ_W  = 11;
  localparam int SW_W   = 5;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef logic [DATA_W-1:0] cap_word_t;

  function automatic cap_word_t pack_capture(input logic [SEQ_W-1:0] seq,
                                             input logic [SW_W-1:0]  sw);
    return {seq, sw};
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Button synchronizer plus press/release debounce FSM; emits a one-cycle pulse
// in the cycle after a press is accepted.
module key_debouncer
  import icc_pkg::*;
#(
  parameter int DEBOUNCE_N = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0]            sync_q;
  logic [1:0]            state_q, state_d;
  logic [DEBOUNCE_N-1:0] cnt_q, cnt_d;
  logic                  pulse_q, pulse_d;
  logic                  btn_s;

  assign btn_s   = sync_q[1];
  assign pulse_o = pulse_q;

  // The counter only runs in the two wait states and restarts on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + DEBOUNCE_N'(1);
    pulse_d = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        cnt_d = '0;
        if (btn_s) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (&cnt_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        cnt_d = '0;
        if (!btn_s) state_d = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (&cnt_q) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/input_capture_ctrl.sv
// Debounced button captures {seq, switches} into a small FIFO drained as ring-buffer writes.
// Optional build macro ICC_DROP_OLDEST_EN: a capture into a full FIFO overwrites the oldest entry.
module input_capture_ctrl
  import icc_pkg::*;
#(
  parameter int                DEBOUNCE_N = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'h000100,
  parameter int                RING_WORDS = 16,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        drop_cnt,
  output logic [2:0]        level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(RING_WORDS);

  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  cap_word_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic capture, full, pop, push, overwrite, lost, wr_en;

  key_debouncer #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn),
    .pulse_o(capture)
  );

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  assign push  = capture & (~full | pop);
  assign lost  = capture & full & ~pop;
`ifdef ICC_DROP_OLDEST_EN
  assign overwrite = lost;
`else
  assign overwrite = 1'b0;
`endif
  assign wr_en = push | overwrite;

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_addr  = BASE_ADDR + ADDR_W'(wr_idx_q);
  assign drop_cnt  = drop_cnt_q;
  assign level     = 3'(count_q);

  // An overwrite leaves the occupancy unchanged: when full, write and read pointers coincide.
  always_comb begin
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop | overwrite);
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    seq_d      = wr_en ? seq_q + SEQ_W'(1) : seq_q;
    drop_cnt_d = (lost && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    wr_idx_d   = wr_idx_q;
    if (pop) wr_idx_d = (wr_idx_q == IDX_W'(RING_WORDS - 1)) ? '0 : wr_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      wr_idx_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      wr_idx_q   <= wr_idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pack_capture(seq_q, sw_sync_q);
  end

endmodule

// File: tb/tb_input_capture_ctrl.sv
// Self-checking bench for input_capture_ctrl: directed scenarios plus random press/glitch
// traffic checked against a queue-based model of captures and ring writes.
module tb_input_capture_ctrl;

  localparam logic [23:0] BASE = 24'h000100;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sw;
  logic        btn;
  logic [23:0] out_addr;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_cnt;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq[$];
  logic [10:0] seqM;
  logic [1:0]  widxM;
  int          dropM;
  int          writes;
  logic [23:0] lastAddr;
  logic [15:0] lastData;

  always #5 clk = ~clk;

  input_capture_ctrl #(
    .DEBOUNCE_N(3),
    .BASE_ADDR (BASE),
    .RING_WORDS(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .btn      (btn),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_cnt (drop_cnt),
    .level    (level)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_level"}, 32'(level), 32'(mq.size()));
    checkOutput({tag, "_drop"}, 32'(drop_cnt), 32'(dropM));
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    checkOutput({tag, "_data"}, 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    checkOutput({tag, "_addr"}, 32'(out_addr), 32'(BASE + 24'(widxM)));
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    btn   = 1'b0;
    waitCycles(n);
    reset = 1'b0;
    mq.delete();
    seqM  = '0;
    widxM = '0;
    dropM = 0;
  endtask

  // Behavioural capture rule: a full FIFO with nobody draining loses (or overwrites) the capture.
  task automatic modelCapture(input logic [4:0] swVal, input logic readyVal);
    if (!readyVal && mq.size() == 4) begin
      if (dropM < 255) dropM++;
`ifdef ICC_DROP_OLDEST_EN
      void'(mq.pop_front());
      mq.push_back({seqM, swVal});
      seqM++;
`endif
    end else begin
      mq.push_back({seqM, swVal});
      seqM++;
    end
  endtask

  task automatic applyStimulus(input bit isPress, input logic [4:0] swVal,
                               input logic readyVal, input int highLen);
    sw        = swVal;
    out_ready = readyVal;
    if (isPress) modelCapture(swVal, readyVal);
    btn = 1'b1;
    waitCycles(highLen);
    btn = 1'b0;
    waitCycles(16);
  endtask

  // Scoreboard: each handshake must match the head of the model queue and the ring address.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      writes++;
      lastAddr = out_addr;
      lastData = out_data;
      checkOutput("write_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'hFFFF_FFFF);
      checkOutput("write_addr", 32'(out_addr), 32'(BASE + 24'(widxM)));
      if (mq.size() != 0) void'(mq.pop_front());
      widxM++;
    end
  end

  initial begin
    int w0;
    reset     = 1'b1;
    sw        = '0;
    btn       = 1'b0;
    out_ready = 1'b0;
    writes    = 0;
    lastAddr  = '0;
    lastData  = '0;

    doReset(3);
    checkState("reset");
    checkOutput("reset_addr", 32'(out_addr), 32'h000100);
    checkOutput("reset_data", 32'(out_data), 32'h0);

    // Clean press
    applyStimulus(1'b1, 5'h0A, 1'b1, 12);
    checkOutput("clean_writes", 32'(writes), 32'd1);
    checkOutput("clean_addr", 32'(lastAddr), 32'h000100);
    checkOutput("clean_data", 32'(lastData), 32'h000A);
    checkState("clean");

    // Bounce rejection
    for (int i = 0; i < 46; i++) begin
      btn = (i < 30) ? ((i / 3) % 2 == 0) : 1'b0;
      waitCycles(1);
      checkOutput("bounce_valid", 32'(out_valid), 32'(mq.size() != 0));
    end
    checkOutput("bounce_writes", 32'(writes), 32'd1);

    // Ring wrap
    doReset(2);
    w0 = writes;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'($urandom), 1'b1, 12);
    checkOutput("wrap_writes", 32'(writes - w0), 32'd5);
    checkOutput("wrap_last_addr", 32'(lastAddr), 32'h000100);
    checkOutput("wrap_last_seq", 32'(lastData[15:5]), 32'd4);
    checkState("wrap");

    // Overflow with nobody draining
    doReset(2);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 5'($urandom), 1'b0, 12);
    checkOutput("ovf_level", 32'(level), 32'd4);
    checkOutput("ovf_drop", 32'(drop_cnt), 32'd2);
`ifdef ICC_DROP_OLDEST_EN
    checkOutput("ovf_head_seq", 32'(out_data[15:5]), 32'd2);
`else
    checkOutput("ovf_head_seq", 32'(out_data[15:5]), 32'd0);
`endif
    checkState("ovf");
    w0 = writes;
    out_ready = 1'b1;
    waitCycles(8);
    checkOutput("ovf_drain_writes", 32'(writes - w0), 32'd4);
    checkState("ovf_drain");

    // Reset mid-operation
    doReset(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'($urandom), 1'b0, 12);
    checkOutput("mid_level_before", 32'(level), 32'd3);
    doReset(1);
    checkOutput("mid_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_level", 32'(level), 32'd0);
    checkOutput("mid_addr", 32'(out_addr), 32'h000100);
    checkOutput("mid_drop", 32'(drop_cnt), 32'd0);
    w0 = writes;
    out_ready = 1'b1;
    waitCycles(10);
    checkOutput("mid_no_write", 32'(writes - w0), 32'd0);
    applyStimulus(1'b1, 5'h15, 1'b1, 12);
    checkState("mid_recover");

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      bit   isPress;
      logic rdy;
      isPress = ($urandom_range(0, 3) != 0);
      rdy     = ($urandom_range(0, 9) < 4);
      applyStimulus(isPress, 5'($urandom), rdy, isPress ? 12 : int'($urandom_range(1, 4)));
      checkState("rand");
    end

    out_ready = 1'b1;
    waitCycles(12);
    checkOutput("final_drained", 32'(mq.size()), 32'd0);
    checkState("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
